// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the special BUBBLE/HALT encodings
// and the fetch-stage state type.
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int PTR_W   = 4;
    localparam int CNT_W   = 16;

    localparam logic [INSTR_W-1:0] BUBBLE = 9'b000000000;
    localparam logic [INSTR_W-1:0] HALT   = 9'b111111111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Jump-target register file: asynchronous read, synchronous write, cleared on reset.
module jump_lut #(
    parameter int PTR_W = 4,
    parameter int PC_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [PC_W-1:0]  wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [PC_W-1:0]  rd_data
);

    localparam int DEPTH = 2 ** PTR_W;

    logic [PC_W-1:0]  mem [DEPTH];
    logic [DEPTH-1:0] wr_sel;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_en && (wr_addr == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= wr_data;
                end
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC sequencing, jump-LUT redirection and the
// IDLE -> RUN -> DONE run controller with a saturating cycle counter.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W     = cpu_pkg::PC_W,
    parameter int INSTR_W  = cpu_pkg::INSTR_W,
    parameter int PTR_W    = cpu_pkg::PTR_W,
    parameter int START_PC = 0,
    parameter int CNT_W    = cpu_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [PC_W-1:0]    rom_addr,
    input  logic [INSTR_W-1:0] rom_data,
    output logic [INSTR_W-1:0] instr,
    input  logic               pc_jmp_en,
    input  logic [PTR_W-1:0]   lut_ptr,
    input  logic               lut_wr_en,
    input  logic [PTR_W-1:0]   lut_wr_addr,
    input  logic [PC_W-1:0]    lut_wr_data,
    output logic               done,
    output logic               pc_overflow,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam logic [PC_W-1:0] START_PC_V = PC_W'(START_PC);

    fetch_state_t     state_reg;
    logic [PC_W-1:0]  pc_reg;
    logic             done_reg;
    logic             ovf_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [PC_W-1:0]  jump_target;
    logic             running;
    logic             is_halt;

    assign running = (state_reg == RUN);
    assign instr   = running ? rom_data : INSTR_W'(BUBBLE);
    assign is_halt = running && (rom_data == INSTR_W'(HALT));

    // The table is frozen while a program runs so a jump target cannot change under it.
    jump_lut #(
        .PTR_W (PTR_W),
        .PC_W  (PC_W)
    ) u_jump_lut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (lut_wr_en && !running),
        .wr_addr (lut_wr_addr),
        .wr_data (lut_wr_data),
        .rd_addr (lut_ptr),
        .rd_data (jump_target)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= START_PC_V;
            done_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg <= RUN;
                        pc_reg    <= START_PC_V;
                        done_reg  <= 1'b0;
                        ovf_reg   <= 1'b0;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    if (cnt_reg != '1) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                    // HALT wins over any jump request; the PC stays parked on the HALT word.
                    if (is_halt) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end else if (pc_jmp_en) begin
                        pc_reg <= jump_target;
                    end else if (pc_reg == '1) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        ovf_reg   <= 1'b1;
                    end else begin
                        pc_reg <= pc_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rom_addr    = pc_reg;
    assign done        = done_reg;
    assign pc_overflow = ovf_reg;
    assign cycle_count = cnt_reg;

endmodule
